fpu_scoreboard: RTL and testbench

Decode-stage hazard tracker for the floating-point pipeline. It sits directly upstream of `fpu_controller`. It records the destination of every FPU arithmetic op issued into the fixed 3-cycle FPU pipeline, and stalls decode while a later instruction reads or rewrites an FP register whose result is still in flight. It also checks the writeback stream coming back from `fpu_controller` against its own bookkeeping and latches an error on any mismatch.

---
 rtl/fpu_scoreboard.sv | 95 +++++++++
 tb/tb_fpu_scoreboard.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_scoreboard.sv
// Decode-stage hazard tracker for the fixed-latency FPU pipe: stall, fpu_issue and busy are combinational from inst and cnt.
// Stalls decode on RAW/WAW against in-flight FPU results and latches a sticky error on any writeback the counters did not predict.
module fpu_scoreboard #(
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic        issue,
  input  logic        ext_rs_fp,
  input  logic        ext_rt_fp,
  input  logic        wb_enable,
  input  logic [4:0]  wb_addr,
  output logic        stall,
  output logic        fpu_issue,
  output logic [31:0] busy,
  output logic        idle,
  output logic        error
);

  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] cnt_q [32];
  logic [CW-1:0] cnt_d [32];
  logic          error_q, error_d;

  logic [5:0] opcode;
  logic [4:0] rs, rt, rd;
  logic       is_fpu, reads_rs, reads_rt;
  logic       raw, waw;
  logic       wb_unexpected, wb_missing;
  logic       inst_unused;

  assign opcode      = inst[31:26];
  assign rs          = inst[25:21];
  assign rt          = inst[20:16];
  assign rd          = inst[15:11];
  assign inst_unused = ^inst[10:0];

  // 110000..110101; finv (110100) and fsqrt (110101) are single-operand
  assign is_fpu   = (opcode[5:3] == 3'b110) && (opcode[2:0] <= 3'b101);
  assign reads_rs = is_fpu | ext_rs_fp;
  assign reads_rt = is_fpu ? (opcode[2:1] != 2'b10) : ext_rt_fp;

  always_comb begin
    for (int r = 0; r < 32; r++) begin
      busy[r] = (cnt_q[r] != '0);
    end
  end

  assign raw       = (reads_rs & busy[rs]) | (reads_rt & busy[rt]);
  assign waw       = is_fpu & busy[rd];
  assign stall     = issue & (raw | waw);
  assign fpu_issue = issue & is_fpu & ~stall;
  assign idle      = (busy == 32'h0);
  assign error     = error_q;

  always_comb begin
    for (int r = 0; r < 32; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CNT_ONE : cnt_q[r];
      if (fpu_issue && (rd == 5'(r))) begin
        cnt_d[r] = CNT_LOAD;
      end
    end
  end

  // A count of 1 marks the single cycle in which fpu_controller must write r back.
  always_comb begin
    wb_unexpected = wb_enable && (cnt_q[wb_addr] != CNT_ONE);
    wb_missing    = 1'b0;
    for (int r = 0; r < 32; r++) begin
      if ((cnt_q[r] == CNT_ONE) && !(wb_enable && (wb_addr == 5'(r)))) begin
        wb_missing = 1'b1;
      end
    end
    error_d = error_q | wb_unexpected | wb_missing;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= '0;
      end
      error_q <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      error_q <= error_d;
    end
  end

endmodule

// File: tb/tb_fpu_scoreboard.sv
// Bench for fpu_scoreboard: directed hazard/checker scenarios plus a randomized stream against a time-based model.
module tb_fpu_scoreboard;
  localparam int L = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst;
  logic        issue, ext_rs_fp, ext_rt_fp, wb_enable;
  logic [4:0]  wb_addr;
  logic        stall, fpu_issue, idle, error;
  logic [31:0] busy;

  fpu_scoreboard #(.LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .issue(issue),
    .ext_rs_fp(ext_rs_fp), .ext_rt_fp(ext_rt_fp),
    .wb_enable(wb_enable), .wb_addr(wb_addr),
    .stall(stall), .fpu_issue(fpu_issue), .busy(busy), .idle(idle), .error(error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int issue_t [32];
  bit err_m;
  bit auto_wb;
  bit wb_noise;
  // {stall, fpu_issue, busy[31:0], idle, error}
  logic [35:0] obs_v, exp_v;

  task automatic model_reset();
    for (int r = 0; r < 32; r++) issue_t[r] = -100;
    err_m = 1'b0;
  endtask

  task automatic set_inst(input int op, input int rs, input int rt, input int rd,
                          input bit iss = 1'b1, input bit ers = 1'b0, input bit ert = 1'b0);
    inst      = {op[5:0], rs[4:0], rt[4:0], rd[4:0], 11'h0};
    issue     = iss;
    ext_rs_fp = ers;
    ext_rt_fp = ert;
  endtask

  // One cycle: entered and left at posedge+1. A result issued at cycle t is
  // in flight during t+1..t+L and written back at t+L.
  task automatic tick();
    logic [5:0]  op;
    int          rs, rt, rd;
    bit          fpu, rrs, rrt, st, fi, unexp, miss;
    logic [31:0] bm;
    if (auto_wb) begin
      wb_enable = 1'b0;
      wb_addr   = 5'd0;
      for (int r = 0; r < 32; r++) begin
        if (issue_t[r] + L == cyc) begin
          wb_enable = 1'b1;
          wb_addr   = 5'(r);
        end
      end
      if (wb_noise && ($urandom_range(0, 9) == 0)) begin
        wb_enable = 1'($urandom);
        wb_addr   = 5'($urandom_range(0, 7));
      end
    end
    op  = inst[31:26];
    rs  = int'(inst[25:21]);
    rt  = int'(inst[20:16]);
    rd  = int'(inst[15:11]);
    fpu = (op >= 6'd48) && (op <= 6'd53);
    rrs = fpu || ext_rs_fp;
    rrt = fpu ? (op < 6'd52) : ext_rt_fp;
    for (int r = 0; r < 32; r++) bm[r] = (cyc > issue_t[r]) && (cyc <= issue_t[r] + L);
    st    = issue && ((rrs && bm[rs]) || (rrt && bm[rt]) || (fpu && bm[rd]));
    fi    = issue && fpu && !st;
    exp_v = {st, fi, bm, (bm == 32'h0), err_m};
    @(negedge clk);
    obs_v = {stall, fpu_issue, busy, idle, error};
    unexp = wb_enable && (cyc != issue_t[wb_addr] + L);
    miss  = 1'b0;
    for (int r = 0; r < 32; r++) begin
      if ((issue_t[r] + L == cyc) && !(wb_enable && (wb_addr == 5'(r)))) miss = 1'b1;
    end
    @(posedge clk);
    #1;
    if (unexp || miss) err_m = 1'b1;
    if (fi) issue_t[rd] = cyc;
    cyc++;
  endtask

  task automatic do_reset();
    issue     = 1'b0;
    wb_enable = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc++;
  endtask

  task automatic drain();
    issue = 1'b0;
    repeat (L + 1) begin
      tick();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL drain cyc %0d got %h want %h", cyc, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({busy, idle, error} !== {32'h0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_init got busy=%h idle=%b error=%b want 0/1/0", busy, idle, error);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc++;
  endtask

  task automatic test_reset_midrun();
    auto_wb   = 1'b0;
    wb_enable = 1'b1;
    wb_addr   = 5'd20;
    set_inst(48, 10, 11, 1);
    tick();
    wb_enable = 1'b0;
    set_inst(50, 12, 13, 2);
    tick();
    set_inst(53, 14, 0, 3);
    tick();
    n_cmp++;
    if (obs_v[0] !== 1'b1 || obs_v[33:2] !== 32'h6) begin
      n_fail++;
      $display("FAIL midrun_pre got busy=%h error=%b want 6/1", obs_v[33:2], obs_v[0]);
    end
    issue = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, idle, error, stall, fpu_issue} !== {32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midrun_reset got busy=%h idle=%b error=%b want 0/1/0", busy, idle, error);
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc++;
    auto_wb = 1'b1;
    drain();
  endtask

  task automatic test_independent();
    logic [31:0] busy_tab [4];
    busy_tab = '{32'h0, 32'h2, 32'h6, 32'hE};
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: set_inst(48, 10, 11, 1);
        1: set_inst(50, 12, 13, 2);
        2: set_inst(53, 14, 15, 3);
        default: issue = 1'b0;
      endcase
      tick();
      n_cmp++;
      if (obs_v !== exp_v || obs_v[33:2] !== busy_tab[k] || obs_v[35] !== 1'b0) begin
        n_fail++;
        $display("FAIL indep k=%0d got %h want %h busy %h", k, obs_v, exp_v, busy_tab[k]);
      end
    end
    drain();
    n_cmp++;
    if (obs_v[1:0] !== 2'b10) begin
      n_fail++;
      $display("FAIL indep_end got idle/error %b want 10", obs_v[1:0]);
    end
  endtask

  task automatic test_raw();
    set_inst(48, 1, 2, 5);
    tick();
    for (int k = 1; k <= 4; k++) begin
      set_inst(49, 5, 6, 12);
      tick();
      n_cmp++;
      if (obs_v !== exp_v || obs_v[35:34] !== ((k <= 3) ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL raw k=%0d got %h want %h", k, obs_v, exp_v);
      end
    end
    drain();
  endtask

  task automatic test_finv();
    set_inst(50, 1, 2, 7);
    tick();
    set_inst(52, 8, 7, 13);
    tick();
    n_cmp++;
    if (obs_v !== exp_v || obs_v[35:34] !== 2'b01) begin
      n_fail++;
      $display("FAIL finv_rt got %h want %h", obs_v, exp_v);
    end
    drain();
    set_inst(50, 1, 2, 7);
    tick();
    for (int k = 1; k <= 4; k++) begin
      set_inst(0, 1, 7, 14, 1'b1, 1'b0, 1'b1);
      tick();
      n_cmp++;
      if (obs_v !== exp_v || obs_v[35:34] !== ((k <= 3) ? 2'b10 : 2'b00)) begin
        n_fail++;
        $display("FAIL ext_rt k=%0d got %h want %h", k, obs_v, exp_v);
      end
    end
    drain();
  endtask

  task automatic test_waw();
    set_inst(48, 1, 2, 9);
    tick();
    for (int k = 1; k <= 8; k++) begin
      if (k <= 4) set_inst(50, 3, 4, 9);
      else issue = 1'b0;
      tick();
      n_cmp++;
      if (obs_v !== exp_v || obs_v[35] !== (k <= 3) || obs_v[2+9] !== (k != 4 && k != 8)) begin
        n_fail++;
        $display("FAIL waw k=%0d got %h want %h", k, obs_v, exp_v);
      end
    end
    drain();
  endtask

  task automatic test_checker();
    auto_wb   = 1'b0;
    wb_enable = 1'b0;
    set_inst(48, 1, 2, 4);
    tick();
    issue = 1'b0;
    tick();
    wb_enable = 1'b1;
    wb_addr   = 5'd4;
    tick();
    wb_enable = 1'b0;
    n_cmp++;
    if (obs_v !== exp_v || obs_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL early_wb_t2 got %h want %h", obs_v, exp_v);
    end
    tick();
    n_cmp++;
    if (obs_v !== exp_v || obs_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL early_wb_t3 got %h want %h", obs_v, exp_v);
    end
    do_reset();
    set_inst(48, 1, 2, 4);
    tick();
    issue = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_cmp++;
      if (obs_v !== exp_v || obs_v[0] !== (k == 4)) begin
        n_fail++;
        $display("FAIL missing_wb k=%0d got %h want %h", k, obs_v, exp_v);
      end
    end
    do_reset();
    auto_wb = 1'b1;
  endtask

  task automatic test_random(input int cycles, input bit noise);
    int sel;
    wb_noise = noise;
    issue    = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      if (!(issue && exp_v[35])) begin
        sel = $urandom_range(0, 7);
        set_inst((sel < 6) ? 48 + sel : ((sel == 6) ? 0 : 35),
                 $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                 ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom));
      end
      tick();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL random cyc %0d got %h want %h", cyc, obs_v, exp_v);
      end
    end
    wb_noise = 1'b0;
    drain();
    do_reset();
  endtask

  initial begin
    rst_n     = 1'b0;
    inst      = 32'h0;
    issue     = 1'b0;
    ext_rs_fp = 1'b0;
    ext_rt_fp = 1'b0;
    wb_enable = 1'b0;
    wb_addr   = 5'd0;
    auto_wb   = 1'b1;
    wb_noise  = 1'b0;
    exp_v     = '0;
    model_reset();
    test_reset();
    test_reset_midrun();
    test_independent();
    test_raw();
    test_finv();
    test_waw();
    test_checker();
    test_random(400, 1'b0);
    test_random(300, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
